// File: rtl/traffic_light_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor_if
// Purpose  : Lamp bundle of the two-road traffic light controller.
//            The controller (or a bench) drives it through the master
//            modport; the passive monitor observes it through the slave
//            modport.
// Signals  : north_green/yellow/red, east_green/yellow/red (1 bit each)
// Revision : 1.0  initial release
// ============================================================================
interface traffic_light_monitor_if;
  logic north_green;
  logic north_yellow;
  logic north_red;
  logic east_green;
  logic east_yellow;
  logic east_red;

  modport master (
    output north_green, north_yellow, north_red,
    output east_green,  east_yellow,  east_red
  );

  modport slave (
    input north_green, north_yellow, north_red,
    input east_green,  east_yellow,  east_red
  );
endinterface
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor
// Purpose  : Passive checker on the lamps of a two-road traffic light.
//            Checks one-lamp-per-road, road conflicts, G->Y->R->G ordering
//            and green/yellow dwell limits. Reports sticky flags, the first
//            error code, a saturating error-cycle count and a saturating
//            count of completed north cycles.
// Ports    : clk, rst (sync, active high), clr_err (sync clear of errors)
//            lamps        : slave view of the six lamp signals
//            err_onehot, err_conflict, err_sequence, err_timing, err_any
//            err_code[2:0]: 0 none, 1 onehot, 2 conflict, 3 sequence, 4 timing
//            err_count, cycle_count [CNT_W-1:0]
// Revision : 1.0  initial release
// ============================================================================
module traffic_light_monitor #(
  parameter int GREEN_MIN     = 4,
  parameter int GREEN_MAX     = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               clr_err,
  traffic_light_monitor_if.slave  lamps,
  output logic                    err_onehot,
  output logic                    err_conflict,
  output logic                    err_sequence,
  output logic                    err_timing,
  output logic                    err_any,
  output logic [2:0]              err_code,
  output logic [CNT_W-1:0]        err_count,
  output logic [CNT_W-1:0]        cycle_count
);

  // Per-road lamp state; c_INV doubles as "no valid history"
  localparam logic [1:0] c_INV = 2'd0;
  localparam logic [1:0] c_G   = 2'd1;
  localparam logic [1:0] c_Y   = 2'd2;
  localparam logic [1:0] c_R   = 2'd3;

  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] c_GREEN_MIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] c_GREEN_MAX = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] c_YELLOW    = CNT_W'(YELLOW_CYCLES);

  // Road index 0 = north, 1 = east
  logic [1:0]       r_prev  [2];
  logic [CNT_W-1:0] r_dwell [2];
  logic [1:0]       r_timed;   // current phase began with an observed transition

  logic [2:0]       w_lamp     [2];
  logic [1:0]       w_cur      [2];
  logic [1:0]       w_nxt_prev [2];
  logic [CNT_W-1:0] w_nxt_dwell[2];
  logic [1:0]       w_nxt_timed;
  logic [1:0]       w_bad;
  logic [1:0]       w_seq;
  logic [1:0]       w_tim;
  logic             w_onehot, w_conflict, w_sequence, w_timing, w_any, w_cycle;
  logic [2:0]       w_code;

  logic             r_onehot, r_conflict, r_sequence, r_timing;
  logic [2:0]       r_code;
  logic [CNT_W-1:0] r_err_cnt, r_cyc_cnt;

  assign w_lamp[0] = {lamps.north_green, lamps.north_yellow, lamps.north_red};
  assign w_lamp[1] = {lamps.east_green,  lamps.east_yellow,  lamps.east_red};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_bad[k] = 1'b0;
      case (w_lamp[k])
        3'b100:  w_cur[k] = c_G;
        3'b010:  w_cur[k] = c_Y;
        3'b001:  w_cur[k] = c_R;
        default: begin
          w_cur[k] = c_INV;
          w_bad[k] = 1'b1;
        end
      endcase

      w_seq[k] = !w_bad[k] && (r_prev[k] != c_INV) && (w_cur[k] != r_prev[k]) &&
                 !((r_prev[k] == c_G && w_cur[k] == c_Y) ||
                   (r_prev[k] == c_Y && w_cur[k] == c_R) ||
                   (r_prev[k] == c_R && w_cur[k] == c_G));

      // Over-long phases fire only when the dwell first crosses the limit
      w_tim[k] = !w_bad[k] && r_timed[k] &&
                 ((r_prev[k] == c_G && w_cur[k] == c_Y && r_dwell[k] <  c_GREEN_MIN) ||
                  (r_prev[k] == c_G && w_cur[k] == c_G && r_dwell[k] == c_GREEN_MAX) ||
                  (r_prev[k] == c_Y && w_cur[k] == c_R && r_dwell[k] != c_YELLOW)    ||
                  (r_prev[k] == c_Y && w_cur[k] == c_Y && r_dwell[k] == c_YELLOW));

      if (w_bad[k]) begin
        w_nxt_prev[k]  = c_INV;
        w_nxt_dwell[k] = '0;
        w_nxt_timed[k] = 1'b0;
      end else if (w_cur[k] != r_prev[k]) begin
        w_nxt_prev[k]  = w_cur[k];
        w_nxt_dwell[k] = CNT_W'(1);
        w_nxt_timed[k] = (r_prev[k] != c_INV);
      end else begin
        w_nxt_prev[k]  = w_cur[k];
        w_nxt_dwell[k] = (r_dwell[k] == c_CNT_MAX) ? r_dwell[k] : r_dwell[k] + 1'b1;
        w_nxt_timed[k] = r_timed[k];
      end
    end

    w_onehot   = |w_bad;
    // A BAD road has no defined colour, so it cannot take part in a conflict
    w_conflict = !w_bad[0] && !w_bad[1] && (w_cur[0] != c_R) && (w_cur[1] != c_R);
    w_sequence = |w_seq;
    w_timing   = |w_tim;
    w_any      = w_onehot | w_conflict | w_sequence | w_timing;
    w_cycle    = (r_prev[0] == c_R) && (w_cur[0] == c_G);

    if (w_onehot)        w_code = 3'd1;
    else if (w_conflict) w_code = 3'd2;
    else if (w_sequence) w_code = 3'd3;
    else if (w_timing)   w_code = 3'd4;
    else                 w_code = 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        r_prev[k]  <= c_INV;
        r_dwell[k] <= '0;
      end
      r_timed    <= '0;
      r_onehot   <= 1'b0;
      r_conflict <= 1'b0;
      r_sequence <= 1'b0;
      r_timing   <= 1'b0;
      r_code     <= 3'd0;
      r_err_cnt  <= '0;
      r_cyc_cnt  <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        r_prev[k]  <= w_nxt_prev[k];
        r_dwell[k] <= w_nxt_dwell[k];
      end
      r_timed <= w_nxt_timed;

      if (w_cycle && r_cyc_cnt != c_CNT_MAX) r_cyc_cnt <= r_cyc_cnt + 1'b1;

      // Clear takes precedence over errors detected in the same cycle
      if (clr_err) begin
        r_onehot   <= 1'b0;
        r_conflict <= 1'b0;
        r_sequence <= 1'b0;
        r_timing   <= 1'b0;
        r_code     <= 3'd0;
        r_err_cnt  <= '0;
      end else begin
        r_onehot   <= r_onehot   | w_onehot;
        r_conflict <= r_conflict | w_conflict;
        r_sequence <= r_sequence | w_sequence;
        r_timing   <= r_timing   | w_timing;
        if (r_code == 3'd0) r_code <= w_code;
        if (w_any && r_err_cnt != c_CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign err_onehot   = r_onehot;
  assign err_conflict = r_conflict;
  assign err_sequence = r_sequence;
  assign err_timing   = r_timing;
  assign err_any      = r_onehot | r_conflict | r_sequence | r_timing;
  assign err_code     = r_code;
  assign err_count    = r_err_cnt;
  assign cycle_count  = r_cyc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_monitor
// Purpose  : Directed self-checking bench for traffic_light_monitor.
//            Expected outputs are queued as each step is driven and popped
//            and compared once the clock edge consuming that step has passed.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_light_monitor;

  localparam logic [2:0] L_G  = 3'b100;
  localparam logic [2:0] L_Y  = 3'b010;
  localparam logic [2:0] L_R  = 3'b001;
  localparam logic [2:0] L_RG = 3'b101;

  typedef struct {
    string      tag;
    logic [3:0] f;      // {onehot, conflict, sequence, timing}
    logic [2:0] code;
    logic [7:0] ec;
    logic [7:0] cc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_err = 1'b0;
  logic       err_onehot, err_conflict, err_sequence, err_timing, err_any;
  logic [2:0] err_code;
  logic [7:0] err_count, cycle_count;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  traffic_light_monitor_if u_if ();

  traffic_light_monitor #(
    .GREEN_MIN(4), .GREEN_MAX(8), .YELLOW_CYCLES(2), .CNT_W(8)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .clr_err      (clr_err),
    .lamps        (u_if.slave),
    .err_onehot   (err_onehot),
    .err_conflict (err_conflict),
    .err_sequence (err_sequence),
    .err_timing   (err_timing),
    .err_any      (err_any),
    .err_code     (err_code),
    .err_count    (err_count),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string field,
                     input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] f, input logic [2:0] code,
                      input logic [7:0] ec, input logic [7:0] cc);
    exp_t e;
    e.tag = tag; e.f = f; e.code = code; e.ec = ec; e.cc = cc;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    e = sb.pop_front();
    cmp(e.tag, "flags", {4'b0, err_onehot, err_conflict, err_sequence, err_timing}, {4'b0, e.f});
    cmp(e.tag, "err_any", {7'b0, err_any}, {7'b0, |e.f});
    cmp(e.tag, "err_code", {5'b0, err_code}, {5'b0, e.code});
    cmp(e.tag, "err_count", err_count, e.ec);
    cmp(e.tag, "cycle_count", cycle_count, e.cc);
  endtask

  // Drive one sample, let the DUT consume it, then check any queued result
  task automatic step(input logic [2:0] n, input logic [2:0] e, input logic c = 1'b0);
    {u_if.north_green, u_if.north_yellow, u_if.north_red} = n;
    {u_if.east_green,  u_if.east_yellow,  u_if.east_red}  = e;
    clr_err = c;
    @(posedge clk);
    #1;
    if (sb.size() > 0) check_pop();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(L_R, L_R);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] ln, le;

    // Reset state
    push("reset", 4'b0000, 3'd0, 8'd0, 8'd0);
    do_reset();

    // Legal run: N G4/Y2/R8, E R8/G4/Y2, three periods
    for (int rep = 0; rep < 3; rep++) begin
      for (int c = 0; c < 14; c++) begin
        ln = (c < 4) ? L_G : (c < 6) ? L_Y : L_R;
        le = (c < 8) ? L_R : (c < 12) ? L_G : L_Y;
        if (rep == 0 && c == 0)  push("legal_first", 4'b0000, 3'd0, 8'd0, 8'd0);
        if (rep == 1 && c == 0)  push("legal_rep1",  4'b0000, 3'd0, 8'd0, 8'd1);
        if (rep == 2 && c == 13) push("legal_end",   4'b0000, 3'd0, 8'd0, 8'd2);
        step(ln, le);
      end
    end

    // Clear keeps cycle_count; clear beats a simultaneous error
    step(L_R, L_R);
    push("onehot_pre_clr", 4'b1000, 3'd1, 8'd1, 8'd2);
    step(L_RG, L_R);
    push("clr", 4'b0000, 3'd0, 8'd0, 8'd2);
    step(L_R, L_R, 1'b1);
    push("clr_wins", 4'b0000, 3'd0, 8'd0, 8'd2);
    step(L_RG, L_R, 1'b1);

    // Conflict, then stays sticky while a later error does not change the code
    push("reset2", 4'b0000, 3'd0, 8'd0, 8'd0);
    do_reset();
    step(L_G, L_R);
    step(L_G, L_R);
    push("conflict", 4'b0100, 3'd2, 8'd1, 8'd0);
    step(L_G, L_G);
    push("conflict_sticky", 4'b0110, 3'd2, 8'd2, 8'd0);
    step(L_G, L_R);

    // BAD north road with east green: onehot only
    do_reset();
    push("onehot_conflict", 4'b1000, 3'd1, 8'd1, 8'd0);
    step(L_RG, L_G);

    // Illegal G->R
    do_reset();
    step(L_G, L_R);
    step(L_G, L_R);
    push("sequence", 4'b0010, 3'd3, 8'd1, 8'd0);
    step(L_R, L_R);

    // Green held too long: flagged at the 9th green sample, once
    do_reset();
    step(L_R, L_R);
    step(L_G, L_R);
    for (int i = 0; i < 6; i++) step(L_G, L_R);
    push("green8", 4'b0000, 3'd0, 8'd0, 8'd1);
    step(L_G, L_R);
    push("green9", 4'b0001, 3'd4, 8'd1, 8'd1);
    step(L_G, L_R);
    push("green10_once", 4'b0001, 3'd4, 8'd1, 8'd1);
    step(L_G, L_R);

    // Green exactly GREEN_MIN is legal, yellow of 1 cycle is not
    do_reset();
    step(L_R, L_R);
    for (int i = 0; i < 4; i++) step(L_G, L_R);
    push("green_min_ok", 4'b0000, 3'd0, 8'd0, 8'd1);
    step(L_Y, L_R);
    push("yellow_short", 4'b0001, 3'd4, 8'd1, 8'd1);
    step(L_R, L_R);

    // Green shorter than GREEN_MIN
    do_reset();
    step(L_R, L_R);
    for (int i = 0; i < 3; i++) step(L_G, L_R);
    push("green_short", 4'b0001, 3'd4, 8'd1, 8'd1);
    step(L_Y, L_R);

    // Reset mid-yellow discards history: the partial yellow is not timed
    do_reset();
    step(L_R, L_R);
    for (int i = 0; i < 4; i++) step(L_G, L_R);
    step(L_Y, L_R);
    push("rst_mid_yellow", 4'b0000, 3'd0, 8'd0, 8'd0);
    rst = 1'b1;
    step(L_Y, L_R);
    rst = 1'b0;
    step(L_Y, L_R);
    push("after_rst", 4'b0000, 3'd0, 8'd0, 8'd0);
    step(L_R, L_R);
    push("after_rst_cycle", 4'b0000, 3'd0, 8'd0, 8'd1);
    step(L_G, L_R);

    n_cmp++;
    assert (sb.size() == 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
